// File: rtl/usb_pkg.sv
// Shared USB definitions: FSM encodings for the token transmitter and the
// receiver, SYNC pattern, and the CRC5 constants/step function.
package usb_pkg;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_SYNC    = 3'd1,
        TX_PID     = 3'd2,
        TX_TOKEN   = 3'd3,
        TX_CRC     = 3'd4,
        TX_EOP_SE0 = 3'd5,
        TX_EOP_J   = 3'd6
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_SYNC  = 3'd1,
        RX_PID   = 3'd2,
        RX_TOKEN = 3'd3,
        RX_CRC   = 3'd4,
        RX_EOP   = 3'd5
    } rx_state_e;

    // SYNC is sent LSB first: seven 0s then a 1.
    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [4:0] CRC5_INIT = 5'b11111;
    // x^5 + x^2 + 1, x^5 implied by the shift-out.
    localparam logic [4:0] CRC5_POLY = 5'b00101;

    // One serial CRC5 step for a single data bit in transmit order.
    function automatic logic [4:0] crc5_next(input logic [4:0] crc, input logic din);
        logic fb;
        fb = crc[4] ^ din;
        crc5_next = {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-time generator: while enabled, pulses bit_strobe on the last clk of
// every CLKS_PER_BIT-cycle bit period; holds its count at zero when disabled.
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    output logic bit_strobe
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count within the bit, wrapping at the last cycle; clear when idle.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_strobe = en && (cnt_q == LAST);

endmodule

// File: rtl/usb_token_tx.sv
// USB token packet transmitter: SYNC, PID, 11-bit address/endpoint, CRC5,
// with bit stuffing and NRZI, finished by SE0-SE0-J EOP.
//
// Handshake: start is a one-cycle request sampled only while busy=0; the
// fields are captured on that edge. busy is high for the whole packet and
// drops in the same cycle done pulses; that done cycle is already idle, so a
// start presented there is taken immediately.
module usb_token_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [3:0] pid,
    input  logic [6:0] addr,
    input  logic [3:0] endp,
    output logic       busy,
    output logic       done,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_oe,
    output tx_state_e  dbg_state
);

    tx_state_e   state_q, state_d, adv_state;
    logic [3:0]  cnt_q, cnt_d, adv_cnt;   // bit index within the current field
    logic        stuff_q, stuff_d;        // current bit time is a stuffed 0
    logic [2:0]  ones_q, ones_d;          // consecutive 1s ending at the current bit
    logic        nrzi_q, nrzi_d;          // line level, 1 = J
    logic [4:0]  crc_q, crc_d;
    logic [7:0]  pid_q, pid_d;
    logic [10:0] tok_q, tok_d;            // {endp, addr}, bit 0 sent first
    logic        done_q, done_d;
    logic        bit_strobe, timer_en, in_field, adv_is_field, need_stuff, nxt_bit;

    assign timer_en = (state_q != TX_IDLE);

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .en        (timer_en),
        .bit_strobe(bit_strobe)
    );

    // Data bit at a given field position; CRC goes out inverted, bit 4 first.
    function automatic logic field_bit(input tx_state_e st, input logic [3:0] idx,
                                       input logic [7:0] pid_byte, input logic [10:0] token,
                                       input logic [4:0] crc);
        logic [4:0] crc_field;
        crc_field = ~crc;
        case (st)
            TX_SYNC:  field_bit = SYNC_BYTE[idx[2:0]];
            TX_PID:   field_bit = pid_byte[idx[2:0]];
            TX_TOKEN: field_bit = token[idx];
            TX_CRC:   field_bit = crc_field[3'd4 - idx[2:0]];
            default:  field_bit = 1'b1;
        endcase
    endfunction

    assign in_field     = state_q inside {TX_SYNC, TX_PID, TX_TOKEN, TX_CRC};
    assign adv_is_field = adv_state inside {TX_SYNC, TX_PID, TX_TOKEN, TX_CRC};
    // A stuffed 0 follows the sixth consecutive 1, including the last CRC bit.
    assign need_stuff   = in_field && !stuff_q && (ones_q == 3'd6);

    // Field position that follows the current data bit.
    always_comb begin
        adv_state = state_q;
        adv_cnt   = cnt_q + 4'd1;
        case (state_q)
            TX_SYNC:    if (cnt_q == 4'd7)  begin adv_state = TX_PID;     adv_cnt = '0; end
            TX_PID:     if (cnt_q == 4'd7)  begin adv_state = TX_TOKEN;   adv_cnt = '0; end
            TX_TOKEN:   if (cnt_q == 4'd10) begin adv_state = TX_CRC;     adv_cnt = '0; end
            TX_CRC:     if (cnt_q == 4'd4)  begin adv_state = TX_EOP_SE0; adv_cnt = '0; end
            TX_EOP_SE0: if (cnt_q == 4'd1)  begin adv_state = TX_EOP_J;   adv_cnt = '0; end
            TX_EOP_J:   begin adv_state = TX_IDLE; adv_cnt = '0; end
            default:    adv_cnt = '0;
        endcase
    end

    // Next-state: accept start in IDLE, otherwise step one bit per strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stuff_d = stuff_q;
        ones_d  = ones_q;
        nrzi_d  = nrzi_q;
        crc_d   = crc_q;
        pid_d   = pid_q;
        tok_d   = tok_q;
        done_d  = 1'b0;
        nxt_bit = 1'b1;
        if (state_q == TX_IDLE) begin
            if (start) begin
                // First SYNC bit is a 0: toggle from the idle J to K.
                state_d = TX_SYNC;
                cnt_d   = '0;
                stuff_d = 1'b0;
                ones_d  = '0;
                nrzi_d  = 1'b0;
                crc_d   = CRC5_INIT;
                pid_d   = {~pid, pid};
                tok_d   = {endp, addr};
            end
        end else if (bit_strobe) begin
            // CRC absorbs each real TOKEN bit as it leaves the wire.
            if (state_q == TX_TOKEN && !stuff_q) begin
                crc_d = crc5_next(crc_q, tok_q[cnt_q]);
            end
            if (need_stuff) begin
                stuff_d = 1'b1;
                ones_d  = '0;
                nrzi_d  = ~nrzi_q;
            end else begin
                stuff_d = 1'b0;
                state_d = adv_state;
                cnt_d   = adv_cnt;
                nxt_bit = field_bit(adv_state, adv_cnt, pid_q, tok_q, crc_d);
                if (adv_is_field) begin
                    ones_d = nxt_bit ? ones_q + 3'd1 : 3'd0;
                    if (!nxt_bit) begin
                        nrzi_d = ~nrzi_q;
                    end
                end else begin
                    ones_d = '0;
                    nrzi_d = 1'b1;
                end
                done_d = (state_q == TX_EOP_J);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            stuff_q <= 1'b0;
            ones_q  <= '0;
            nrzi_q  <= 1'b1;
            crc_q   <= CRC5_INIT;
            pid_q   <= '0;
            tok_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stuff_q <= stuff_d;
            ones_q  <= ones_d;
            nrzi_q  <= nrzi_d;
            crc_q   <= crc_d;
            pid_q   <= pid_d;
            tok_q   <= tok_d;
            done_q  <= done_d;
        end
    end

    // Line drive: SE0 in the first EOP phase, J when idle or closing EOP.
    always_comb begin
        d_plus  = nrzi_q;
        d_minus = ~nrzi_q;
        if (state_q == TX_EOP_SE0) begin
            d_plus  = 1'b0;
            d_minus = 1'b0;
        end else if (state_q == TX_IDLE || state_q == TX_EOP_J) begin
            d_plus  = 1'b1;
            d_minus = 1'b0;
        end
    end

    assign busy      = (state_q != TX_IDLE);
    assign tx_oe     = (state_q != TX_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_usb_token_tx.sv
// Bench for usb_token_tx: directed packets plus random tokens decoded from the
// wire by an NRZI/destuff decoder and compared against an expected queue.
module tb_usb_token_tx;

    localparam int CLKS = 8;
    localparam int MAXC = 64 * CLKS;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] pid = '0;
    logic [6:0] addr = '0;
    logic [3:0] endp = '0;
    logic       busy, done, d_plus, d_minus, tx_oe;
    usb_pkg::tx_state_e dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] exp_q[$];

    logic [1:0] line_a [0:MAXC];
    logic       oe_a   [0:MAXC];
    logic       busy_a [0:MAXC];
    int         done_cyc;

    logic [1:0] ls    [0:63];
    logic       dbits [0:63];
    logic [7:0] r_sync, r_pid;
    logic [6:0] r_addr;
    logic [3:0] r_endp;
    logic [4:0] r_crc;
    int         r_bits, r_stuffs, r_ndata;
    logic       r_hold_ok, r_oe_ok, r_eop_ok, r_stuff_ok;

    usb_token_tx #(
        .CLKS_PER_BIT(CLKS)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .pid      (pid),
        .addr     (addr),
        .endp     (endp),
        .busy     (busy),
        .done     (done),
        .d_plus   (d_plus),
        .d_minus  (d_minus),
        .tx_oe    (tx_oe),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference CRC5 field (inverted remainder) over addr[0..6], endp[0..3].
    function automatic logic [4:0] crc5_field(input logic [6:0] a, input logic [3:0] e);
        logic [4:0]  c;
        logic [10:0] t;
        c = 5'b11111;
        t = {e, a};
        for (int i = 0; i < 11; i++) begin
            if (c[4] ^ t[i]) c = {c[3:0], 1'b0} ^ 5'b00101;
            else             c = {c[3:0], 1'b0};
        end
        return ~c;
    endfunction

    // Number of stuffed bits expected over SYNC..CRC in wire order.
    function automatic int exp_stuffs(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e);
        logic [31:0] s;
        logic [4:0]  cf;
        int          ones, n;
        cf = crc5_field(a, e);
        s = {cf[0], cf[1], cf[2], cf[3], cf[4], e, a, ~p, p, 8'h80};
        ones = 0;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (s[i]) begin
                ones++;
                if (ones == 6) begin
                    n++;
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        return n;
    endfunction

    // Record line/oe/busy each cycle from the first SYNC cycle until done.
    task automatic capture(input int mid);
        done_cyc = 0;
        for (int c = 1; c <= MAXC; c++) begin
            line_a[c] = {d_plus, d_minus};
            oe_a[c]   = tx_oe;
            busy_a[c] = busy;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            start = (c == mid);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Pulse start (now=1: in the current cycle), scramble inputs, capture.
    task automatic send(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                        input bit now, input int mid);
        if (!now) @(negedge clk);
        start = 1'b1;
        pid   = p;
        addr  = a;
        endp  = e;
        exp_q.push_back({~p, p, a, e, crc5_field(a, e)});
        @(negedge clk);
        start = 1'b0;
        pid   = 4'($urandom);
        addr  = 7'($urandom);
        endp  = 4'($urandom);
        capture(mid);
    endtask

    // Split captured cycles into bit times, NRZI-decode and remove stuffing.
    task automatic decode();
        int         nb, ones, k;
        logic [1:0] prev;
        logic       bitv;
        nb = (done_cyc - 1) / CLKS;
        r_bits = nb;
        r_hold_ok = ((done_cyc - 1) % CLKS == 0) && (nb >= 4);
        if (nb > 64) nb = 64;
        r_oe_ok = 1'b1;
        for (int b = 0; b < nb; b++) begin
            ls[b] = line_a[b*CLKS+1];
            for (int j = 0; j < CLKS; j++) begin
                if (line_a[b*CLKS+1+j] !== ls[b]) r_hold_ok = 1'b0;
                if (oe_a[b*CLKS+1+j] !== 1'b1 || busy_a[b*CLKS+1+j] !== 1'b1) r_oe_ok = 1'b0;
            end
        end
        r_eop_ok = (nb >= 3) && (ls[nb-3] == LS_SE0) && (ls[nb-2] == LS_SE0) && (ls[nb-1] == LS_J);
        prev = LS_J;
        ones = 0;
        k = 0;
        r_stuffs = 0;
        r_stuff_ok = 1'b1;
        for (int b = 0; b < nb - 3; b++) begin
            if (ls[b] != LS_J && ls[b] != LS_K) r_stuff_ok = 1'b0;
            bitv = (ls[b] == prev);
            prev = ls[b];
            if (ones == 6) begin
                if (bitv) r_stuff_ok = 1'b0;
                r_stuffs++;
                ones = 0;
            end else begin
                if (k < 64) dbits[k] = bitv;
                k++;
                ones = bitv ? ones + 1 : 0;
            end
        end
        r_ndata = k;
        for (int i = 0; i < 8; i++) begin
            r_sync[i] = dbits[i];
            r_pid[i]  = dbits[8+i];
        end
        for (int i = 0; i < 7; i++) r_addr[i] = dbits[16+i];
        for (int i = 0; i < 4; i++) r_endp[i] = dbits[23+i];
        for (int i = 0; i < 5; i++) r_crc[4-i] = dbits[27+i];
    endtask

    // Scoreboard check of one captured packet.
    task automatic check_packet(input string tag, input int exp_bits);
        logic [23:0] exp_v;
        exp_v = exp_q.pop_front();
        check_eq($sformatf("%s_done_seen", tag), done_cyc != 0, 1);
        if (done_cyc != 0) begin
            decode();
            check_eq($sformatf("%s_latency", tag), done_cyc - 1, exp_bits * CLKS);
            check_eq($sformatf("%s_hold", tag), r_hold_ok, 1);
            check_eq($sformatf("%s_oe_busy", tag), r_oe_ok, 1);
            check_eq($sformatf("%s_eop", tag), r_eop_ok, 1);
            check_eq($sformatf("%s_stuff_ok", tag), r_stuff_ok, 1);
            check_eq($sformatf("%s_ndata", tag), r_ndata, 32);
            check_eq($sformatf("%s_sync", tag), r_sync, 8'h80);
            check_eq($sformatf("%s_token", tag), {r_pid, r_addr, r_endp, r_crc}, exp_v);
            check_eq($sformatf("%s_done_idle", tag),
                     {line_a[done_cyc], oe_a[done_cyc], busy_a[done_cyc]}, {LS_J, 2'b00});
        end
    endtask

    initial begin
        int         dcount, bcount;
        logic       hold_ok;
        logic [3:0] rp;
        logic [6:0] ra;
        logic [3:0] re;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("rst_lines", {d_plus, d_minus}, LS_J);
        check_eq("rst_oe_busy_done", {tx_oe, busy, done}, 3'b000);
        check_eq("rst_state", dbg_state, usb_pkg::TX_IDLE);
        n_rst = 1'b1;
        @(negedge clk);
        check_eq("idle_after_rst", {d_plus, d_minus, tx_oe, busy, done}, {LS_J, 3'b000});

        // SETUP to address 0, endpoint 0.
        send(4'hD, 7'h00, 4'h0, 1'b0, 0);
        check_packet("setup", 35);
        check_eq("setup_byte1", r_pid, 8'h2D);
        check_eq("setup_byte2", {r_endp[0], r_addr}, 8'h00);
        check_eq("setup_byte3", {r_crc[0], r_crc[1], r_crc[2], r_crc[3], r_crc[4], r_endp[3:1]}, 8'h10);
        check_eq("setup_stuffs", r_stuffs, 0);
        check_eq("setup_first_k", line_a[1], LS_K);
        @(negedge clk);
        check_eq("setup_done_width", done, 1'b0);

        // IN to 0x7F/0xF: one stuffed bit after six address 1s.
        send(4'h9, 7'h7F, 4'hF, 1'b0, 0);
        check_packet("in", 36);
        check_eq("in_byte1", r_pid, 8'h69);
        check_eq("in_crc", r_crc, 5'b00010);
        check_eq("in_byte3", {r_crc[0], r_crc[1], r_crc[2], r_crc[3], r_crc[4], r_endp[3:1]}, 8'h47);
        check_eq("in_stuffs", r_stuffs, 1);
        hold_ok = 1'b1;
        for (int b = 16; b <= 21; b++) if (ls[b] != ls[15]) hold_ok = 1'b0;
        check_eq("in_hold6", hold_ok, 1'b1);
        check_eq("in_stuff_toggle", ls[22] != ls[21], 1'b1);

        // Second start mid-PID must be ignored.
        send(4'h1, 7'h05, 4'h2, 1'b0, 100);
        check_packet("midpid", 35 + exp_stuffs(4'h1, 7'h05, 4'h2));
        dcount = 0;
        bcount = 0;
        repeat (40 * CLKS) begin
            @(negedge clk);
            if (done) dcount++;
            if (busy) bcount++;
        end
        check_eq("midpid_extra_done", dcount, 0);
        check_eq("midpid_extra_busy", bcount, 0);

        // Reset in the middle of TOKEN.
        @(negedge clk);
        start = 1'b1; pid = 4'h5; addr = 7'h3A; endp = 4'h7;
        @(negedge clk);
        start = 1'b0;
        repeat (170) @(negedge clk);
        check_eq("rst_mid_in_token", dbg_state, usb_pkg::TX_TOKEN);
        n_rst = 1'b0;
        #1;
        check_eq("rst_mid_async_oe", tx_oe, 1'b0);
        @(negedge clk);
        check_eq("rst_mid_lines", {d_plus, d_minus}, LS_J);
        check_eq("rst_mid_oe_busy_done", {tx_oe, busy, done}, 3'b000);
        n_rst = 1'b1;
        dcount = 0;
        repeat (40 * CLKS) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check_eq("rst_mid_quiet", dcount, 0);
        send(4'h9, 7'h3A, 4'h7, 1'b0, 0);
        check_packet("after_rst", 35 + exp_stuffs(4'h9, 7'h3A, 4'h7));

        // Back-to-back: second start in the done cycle.
        send(4'hD, 7'h12, 4'h3, 1'b0, 0);
        check_packet("b2b_a", 35 + exp_stuffs(4'hD, 7'h12, 4'h3));
        send(4'h9, 7'h6C, 4'hA, 1'b1, 0);
        check_eq("b2b_sync_start", {line_a[1], oe_a[1]}, {LS_K, 1'b1});
        check_packet("b2b_b", 35 + exp_stuffs(4'h9, 7'h6C, 4'hA));

        // Random tokens through the wire decoder.
        for (int n = 0; n < 100; n++) begin
            rp = 4'($urandom_range(0, 15));
            ra = 7'($urandom_range(0, 127));
            re = 4'($urandom_range(0, 15));
            send(rp, ra, re, 1'b0, 0);
            check_packet($sformatf("rand%0d", n), 35 + exp_stuffs(rp, ra, re));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
